// File: rtl/fft_frame_sequencer_if.sv
// Stream bundle for fft_frame_sequencer: audio sample input and magnitude output handshakes.
interface fft_frame_sequencer_if #(
    parameter int unsigned FFT_DW   = 16,
    parameter int unsigned NUM_BINS = 512,
    parameter int unsigned MAG_W    = 16
);
    localparam int unsigned BW = $clog2(NUM_BINS);

    logic              s_valid_i;
    logic              s_ready_o;
    logic [FFT_DW-1:0] s_real_i;
    logic [FFT_DW-1:0] s_imag_i;

    logic              m_valid_o;
    logic              m_ready_i;
    logic [MAG_W-1:0]  m_mag_o;
    logic [BW-1:0]     m_index_o;
    logic              m_last_o;
    logic [7:0]        m_bfpexp_o;

    modport master (
        input  s_valid_i, s_real_i, s_imag_i, m_ready_i,
        output s_ready_o, m_valid_o, m_mag_o, m_index_o, m_last_o, m_bfpexp_o
    );

    modport slave (
        output s_valid_i, s_real_i, s_imag_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_mag_o, m_index_o, m_last_o, m_bfpexp_o
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame controller: gates one FFT frame of samples in, then sweeps magnitude bins downstream.
// Optional watchdog on the FFT/magnitude waits is enabled by defining FFT_SEQ_TIMEOUT_EN.
module fft_frame_sequencer #(
    parameter int unsigned FFT_LENGTH     = 1024,
    parameter int unsigned FFT_DW         = 16,
    parameter int unsigned NUM_BINS       = 512,
    parameter int unsigned MAG_W          = 16
`ifdef FFT_SEQ_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable_i,
    fft_frame_sequencer_if.master       bus,
    output logic                        fft_clear_o,
    output logic                        fft_sact_o,
    output logic [FFT_DW-1:0]           fft_real_o,
    output logic [FFT_DW-1:0]           fft_imag_o,
    input  logic                        fft_done_i,
    input  logic [7:0]                  fft_bfpexp_i,
    output logic                        bin_req_o,
    output logic [$clog2(NUM_BINS)-1:0] bin_index_o,
    input  logic                        bin_ack_i,
    input  logic [MAG_W-1:0]            bin_mag_i,
    output logic                        frame_done_o,
    output logic                        busy_o,
    output logic [15:0]                 frame_count_o,
    output logic                        timeout_o
);
    localparam int unsigned SW = $clog2(FFT_LENGTH);
    localparam int unsigned BW = $clog2(NUM_BINS);
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(FFT_LENGTH - 1);
    localparam logic [BW-1:0] LAST_BIN    = BW'(NUM_BINS - 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, LOAD, WAIT_FFT, REQ, WAIT_ACK, OUTPUT, DONE
    } state_t;

    state_t        state;
    logic [SW-1:0] sample_count;

`ifdef FFT_SEQ_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0] wd_count;
`else
    assign timeout_o = 1'b0;
`endif

    // bin_index_o doubles as the bin counter; it is only advanced on entry to REQ
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            sample_count   <= '0;
            fft_clear_o    <= 1'b0;
            fft_sact_o     <= 1'b0;
            fft_real_o     <= '0;
            fft_imag_o     <= '0;
            bin_req_o      <= 1'b0;
            bin_index_o    <= '0;
            frame_done_o   <= 1'b0;
            busy_o         <= 1'b0;
            frame_count_o  <= '0;
            bus.s_ready_o  <= 1'b0;
            bus.m_valid_o  <= 1'b0;
            bus.m_mag_o    <= '0;
            bus.m_index_o  <= '0;
            bus.m_last_o   <= 1'b0;
            bus.m_bfpexp_o <= '0;
`ifdef FFT_SEQ_TIMEOUT_EN
            wd_count       <= '0;
            timeout_o      <= 1'b0;
`endif
        end else begin
            fft_clear_o  <= 1'b0;
            fft_sact_o   <= 1'b0;
            bin_req_o    <= 1'b0;
            frame_done_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable_i) begin
                        fft_clear_o <= 1'b1;
                        busy_o      <= 1'b1;
                        state       <= CLEAR;
                    end
                end

                CLEAR: begin
                    sample_count  <= '0;
                    bus.s_ready_o <= 1'b1;
                    state         <= LOAD;
                end

                LOAD: begin
                    if (bus.s_valid_i && bus.s_ready_o) begin
                        fft_real_o <= bus.s_real_i;
                        fft_imag_o <= bus.s_imag_i;
                        fft_sact_o <= 1'b1;
                        if (sample_count == LAST_SAMPLE) begin
                            bus.s_ready_o <= 1'b0;
                            state         <= WAIT_FFT;
`ifdef FFT_SEQ_TIMEOUT_EN
                            wd_count      <= '0;
`endif
                        end else begin
                            sample_count <= sample_count + 1'b1;
                        end
                    end
                end

                WAIT_FFT: begin
                    if (fft_done_i) begin
                        bus.m_bfpexp_o <= fft_bfpexp_i;
                        bin_index_o    <= '0;
                        bin_req_o      <= 1'b1;
                        state          <= REQ;
                    end
`ifdef FFT_SEQ_TIMEOUT_EN
                    else if (wd_count == WD_LIMIT) begin
                        timeout_o   <= 1'b1;
                        fft_clear_o <= 1'b1;
                        state       <= CLEAR;
                    end else begin
                        wd_count <= wd_count + 1'b1;
                    end
`endif
                end

                REQ: begin
                    state <= WAIT_ACK;
`ifdef FFT_SEQ_TIMEOUT_EN
                    wd_count <= '0;
`endif
                end

                WAIT_ACK: begin
                    if (bin_ack_i) begin
                        bus.m_mag_o   <= bin_mag_i;
                        bus.m_index_o <= bin_index_o;
                        bus.m_last_o  <= (bin_index_o == LAST_BIN);
                        bus.m_valid_o <= 1'b1;
                        state         <= OUTPUT;
                    end
`ifdef FFT_SEQ_TIMEOUT_EN
                    else if (wd_count == WD_LIMIT) begin
                        timeout_o   <= 1'b1;
                        fft_clear_o <= 1'b1;
                        state       <= CLEAR;
                    end else begin
                        wd_count <= wd_count + 1'b1;
                    end
`endif
                end

                OUTPUT: begin
                    if (bus.m_ready_i) begin
                        bus.m_valid_o <= 1'b0;
                        if (bus.m_last_o) begin
                            frame_done_o  <= 1'b1;
                            frame_count_o <= frame_count_o + 16'd1;
                            state         <= DONE;
                        end else begin
                            bin_index_o <= bin_index_o + 1'b1;
                            bin_req_o   <= 1'b1;
                            state       <= REQ;
                        end
                    end
                end

                DONE: begin
                    if (enable_i) begin
                        fft_clear_o <= 1'b1;
                        state       <= CLEAR;
                    end else begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
